// File: rtl/stream_relay_pkg.sv
// rtl/stream_relay_pkg.sv - shared defaults, level width helper and mode enum for stream_relay
package stream_relay_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        MODE_BUF    = 1'b0,
        MODE_BYPASS = 1'b1
    } mode_e;

    // Width needed to represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_relay_fifo.sv
// rtl/stream_relay_fifo.sv - circular storage behind the output register, wraps modulo N
module stream_relay_fifo #(
    parameter  int DATA_W = 8,
    parameter  int N      = 15,
    localparam int PTR_W  = (N > 1) ? $clog2(N) : 1,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [N];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CW'(N));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full store is legal when a pop frees the head slot in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/stream_relay.sv
// rtl/stream_relay.sv - valid-qualified stream relay with buffering, backpressure, drop counting and legacy bypass
module stream_relay
    import stream_relay_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int LVL_W  = level_w(DEPTH),
    localparam int FW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rxd,
    input  logic              rx_dv,
    input  logic              bypass,
    input  logic              tx_ready,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] txd,
    output logic              tx_en,
    output logic              ovf,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] txd_q, txd_d;
    logic              tx_en_q, tx_en_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              byp_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [FW-1:0]     fifo_count;
    logic              pop, drop, leaving;

    stream_relay_fifo #(
        .DATA_W (DATA_W),
        .N      (DEPTH - 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bypass),
        .push_i  (fifo_push),
        .wdata_i (rxd),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        txd_d     = txd_q;
        tx_en_d   = tx_en_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        drop      = 1'b0;
        leaving   = byp_q && !bypass;
        pop       = tx_en_q && tx_ready;

        if (bypass) begin
            txd_d   = rxd;
            tx_en_d = rx_dv;
        end else if (leaving) begin
            tx_en_d = 1'b0;
        end else if (pop) begin
            if (!fifo_empty) begin
                txd_d     = fifo_rdata;
                fifo_pop  = 1'b1;
                fifo_push = rx_dv;
            end else if (rx_dv) begin
                txd_d = rxd;
            end else begin
                tx_en_d = 1'b0;
            end
        end else if (!tx_en_q) begin
            if (rx_dv) begin
                txd_d   = rxd;
                tx_en_d = 1'b1;
            end
        end else if (rx_dv) begin
            if (fifo_full) drop = 1'b1;
            else           fifo_push = 1'b1;
        end

        // A drop in the same cycle as clr_ovf restarts the count at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf)          cnt_d = CNT_W'(1);
            else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            byp_q   <= 1'b0;
        end else begin
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            byp_q   <= bypass;
        end
    end

    assign txd      = txd_q;
    assign tx_en    = tx_en_q;
    assign ovf      = ovf_q;
    assign drop_cnt = cnt_q;
    assign level    = byp_q ? '0 : LVL_W'(fifo_count) + LVL_W'(tx_en_q);

endmodule

// File: tb/tb_stream_relay.sv
// tb/tb_stream_relay.sv - scoreboard bench for stream_relay
module tb_stream_relay;
    import stream_relay_pkg::*;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 4;
    localparam int LVL_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rxd;
    logic              rx_dv, bypass, tx_ready, clr_ovf;
    logic [DATA_W-1:0] txd;
    logic              tx_en, ovf;
    logic [CNT_W-1:0]  drop_cnt;
    logic [LVL_W-1:0]  level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovf;
    int                m_cnt;
    logic              m_byp;

    stream_relay #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_dv    (rx_dv),
        .bypass   (bypass),
        .tx_ready (tx_ready),
        .clr_ovf  (clr_ovf),
        .txd      (txd),
        .tx_en    (tx_en),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model decides acceptance, drops and the expected head.
    task automatic cycle(input logic dv, input logic [DATA_W-1:0] d, input logic rdy,
                         input mode_e md, input logic clr);
        logic pop, acc, drp, byp;
        logic [DATA_W-1:0] tmp;
        byp      = (md == MODE_BYPASS);
        rxd      = d;
        rx_dv    = dv;
        tx_ready = rdy;
        bypass   = byp;
        clr_ovf  = clr;
        pop = 1'b0; acc = 1'b0; drp = 1'b0;
        @(negedge clk);
        if (!byp && !m_byp) begin
            if (q.size() > 0) begin
                check("txd_head", txd, q[0]);
                pop = rdy;
            end
            acc = dv && ((q.size() < DEPTH) || pop);
            drp = dv && !acc;
        end
        @(posedge clk);
        #1;
        if (byp || m_byp) begin
            q.delete();
        end else begin
            if (pop) tmp = q.pop_front();
            if (acc) q.push_back(d);
        end
        if (drp) begin
            m_ovf = 1'b1;
            if (clr)                  m_cnt = 1;
            else if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        m_byp = byp;
        check("level", level, byp ? 0 : q.size());
        check("tx_en", tx_en, byp ? dv : (q.size() > 0));
        if (byp) check("txd_byp", txd, d);
        check("ovf", ovf, m_ovf);
        check("drop_cnt", drop_cnt, m_cnt);
    endtask

    initial begin
        rst_n = 1'b0; rxd = '0; rx_dv = 1'b0; bypass = 1'b0; tx_ready = 1'b0; clr_ovf = 1'b0;
        m_ovf = 1'b0; m_cnt = 0; m_byp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd", txd, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1;

        // empty-path pass-through
        cycle(1, 8'h11, 1, MODE_BUF, 0);
        cycle(1, 8'h22, 1, MODE_BUF, 0);
        cycle(1, 8'h33, 1, MODE_BUF, 0);
        repeat (2) cycle(0, 8'h00, 1, MODE_BUF, 0);

        // backpressure fill to DEPTH, head held stable
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, MODE_BUF, 0);
        check("fill_level", level, DEPTH);
        repeat (2) cycle(0, 8'h00, 0, MODE_BUF, 0);
        check("fill_head", txd, 8'h00);

        // overflow then clear
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'hE0 + i), 0, MODE_BUF, 0);
        check("ovf_cnt3", drop_cnt, 3);
        check("ovf_set", ovf, 1);
        cycle(0, 8'h00, 0, MODE_BUF, 1);
        check("clr_cnt", drop_cnt, 0);

        // full with simultaneous push/pop, then drain: 0xAA emerges 17th
        cycle(1, 8'hAA, 1, MODE_BUF, 0);
        check("full_pushpop_level", level, DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 8'h00, 1, MODE_BUF, 0);

        // bypass with 5 buffered beats, then leave bypass
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h50 + i), 0, MODE_BUF, 0);
        cycle(1, 8'h5A, 0, MODE_BYPASS, 0);
        cycle(0, 8'hC3, 0, MODE_BYPASS, 0);
        cycle(1, 8'h3C, 1, MODE_BYPASS, 0);
        cycle(1, 8'h77, 1, MODE_BUF, 0);
        cycle(1, 8'h78, 1, MODE_BUF, 0);
        cycle(0, 8'h00, 1, MODE_BUF, 0);

        // clear and drop in the same cycle: set wins
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 8'(8'h80 + i), 0, MODE_BUF, 0);
        cycle(1, 8'hF0, 0, MODE_BUF, 1);
        check("clr_drop_cnt", drop_cnt, 1);
        repeat (DEPTH + 1) cycle(0, 8'h00, 1, MODE_BUF, 0);

        // randomized traffic exercising pointer wrap and full boundary
        for (int i = 0; i < 300; i++)
            cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 2) == 1, MODE_BUF, ($urandom % 16) == 0);
        repeat (DEPTH + 1) cycle(0, 8'h00, 1, MODE_BUF, 0);

        // drop counter saturation
        for (int i = 0; i < DEPTH + CNT_MAX + 5; i++) cycle(1, 8'(i), 0, MODE_BUF, 0);
        check("sat_cnt", drop_cnt, CNT_MAX);
        repeat (DEPTH + 1) cycle(0, 8'h00, 1, MODE_BUF, 0);

        // asynchronous reset mid-stream with 7 held
        for (int i = 0; i < 7; i++) cycle(1, 8'(8'h40 + i), 0, MODE_BUF, 0);
        check("pre_rst_level", level, 7);
        #2;
        rst_n = 1'b0;
        rx_dv = 1'b0;
        #1;
        check("arst_txd", txd, 0);
        check("arst_tx_en", tx_en, 0);
        check("arst_level", level, 0);
        check("arst_ovf", ovf, 0);
        check("arst_drop_cnt", drop_cnt, 0);
        q.delete();
        m_ovf = 1'b0; m_cnt = 0; m_byp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 8'h5A, 1, MODE_BUF, 0);
        check("post_rst_txd", txd, 8'h5A);
        cycle(0, 8'h00, 1, MODE_BUF, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_relay.md
Name: stream_relay

Overview:
Parametrised successor to the single-register byte relay. It moves a DATA_W-bit valid-qualified stream from the rx side to the tx side through a DEPTH-entry buffer, and adds tx-side backpressure (tx_ready). Overflows are detected, flagged and counted, because the rx side has no ready. A bypass mode reproduces the legacy 1-cycle register pass-through.

Parameters:
DATA_W, 8, width of rxd/txd
DEPTH, 16, total entries held, including the output register; power of two, >= 2
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rxd  in  DATA_W  input data
rx_dv  in  1  input valid; no backpressure, sampled every cycle
bypass  in  1  1 = legacy pass-through mode, 0 = buffered mode
tx_ready  in  1  downstream ready (buffered mode only)
clr_ovf  in  1  synchronous clear of ovf and drop_cnt
txd  out  DATA_W  output data, registered
tx_en  out  1  output valid, registered
ovf  out  1  sticky overflow flag
drop_cnt  out  CNT_W  count of dropped beats, saturating
level  out  $clog2(DEPTH+1)  entries held (0..DEPTH)

Behaviour:
- Reset (async assert, sync release): txd=0, tx_en=0, ovf=0, drop_cnt=0, level=0. The buffer is logically empty. Reset mid-stream discards all held data.
- Buffered mode (bypass=0):
  - Output register plus (DEPTH-1)-entry circular storage. tx_en=1 iff the output register holds a beat.
  - Pop = tx_en && tx_ready. On pop, the output register loads the storage head if storage is non-empty. Otherwise it loads the incoming beat if rx_dv=1. Otherwise tx_en drops to 0.
  - Empty-path latency: rx_dv sampled at edge N gives tx_en=1, txd=rxd after edge N. This is the same 1-cycle latency as legacy.
  - txd and tx_en hold stable while tx_en=1 && tx_ready=0.
  - Ordering is strictly FIFO; no beat is duplicated or reordered.
  - Full: level==DEPTH. If rx_dv=1 with no pop in that cycle, the beat is dropped, ovf<=1, and drop_cnt increments, saturating at all-ones.
  - Full with rx_dv=1 and pop in the same cycle: the beat is accepted, no drop, level unchanged.
  - level updates on the cycle edge: +1 on accept, -1 on pop, unchanged when both or neither occur.
  - Storage pointers wrap modulo DEPTH-1 with no bubble at wrap.
- Bypass mode (bypass=1):
  - Every edge: txd<=rxd, tx_en<=rx_dv. tx_ready is ignored; there are never drops.
  - Storage is flushed, pointers reset, and level reads 0.
- Mode switching:
  - Entering bypass discards buffered data. Discarded beats are not counted as drops.
  - Leaving bypass: the output register content present at the switch edge is discarded (tx_en=0 next cycle); buffering starts empty.
- clr_ovf: next edge ovf<=0, drop_cnt<=0. If a drop occurs in the same cycle, set wins: ovf=1, drop_cnt=1.

Decomposition:
- Package stream_relay_pkg: default DATA_W/DEPTH/CNT_W constants, a function computing level width, and an enum mode_e {MODE_BUF, MODE_BYPASS} for bench use.
- Sub-module stream_relay_fifo: storage array, read/write pointers, count, full/empty. It is instantiated once, with the output register and drop logic in the top.

Test Plan:
- Empty pass-through: bypass=0, tx_ready=1, drive rxd=0x11,0x22,0x33 on consecutive cycles -> tx_en=1 one cycle later each, txd=0x11,0x22,0x33 back-to-back; level never exceeds 1.
- Backpressure fill: tx_ready=0, write 16 beats 0x00..0x0F -> level=16, ovf=0, txd=0x00 held stable. Then tx_ready=1 -> 0x00..0x0F in order, tx_en=0 after the last.
- Overflow: with level=16 and tx_ready=0, write 3 more beats -> ovf=1, drop_cnt=3, level=16. Pulse clr_ovf with no drop -> ovf=0, drop_cnt=0.
- Full with simultaneous push/pop: level=16, rx_dv=1 with 0xAA, tx_ready=1 -> no drop, level stays 16, and 0xAA is emitted as the 17th beat.
- Bypass mode: bypass=1 with 5 beats buffered and tx_ready=0 -> level=0 next cycle, txd/tx_en track rxd/rx_dv with 1-cycle latency, drop_cnt unchanged.
- Async reset mid-stream: assert rst_n=0 between edges with level=7 -> txd=0, tx_en=0, level=0, ovf=0 immediately. After release, the first beat emerges with 1-cycle latency.
